key_debouncer: RTL

KEY_DEBOUNCER -- requirements
Module: key_debouncer

---
 rtl/key_pkg.sv | 15 +
 rtl/key_channel.sv | 134 +++++++++++++
 rtl/key_debouncer.sv | 34 +++
 3 files changed

// File: rtl/key_pkg.sv
// Shared types and defaults for the push-button debouncer.
// Holds the per-channel FSM encoding and timing constants.
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_HOLD_CYCLES     = 50000000;

endpackage

// File: rtl/key_channel.sv
// One debounced key: 2-flop sync, debounce FSM, hold timer.
// Emits level plus one-cycle press/release/hold pulses.
module key_channel
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);

  logic [1:0]    sync_q;
  logic          s;
  key_state_e    state_q, state_d;
  logic [DW-1:0] db_q, db_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          hev_q, hev_d;
  logic          held;

  // Two-stage synchronizer; reset value means "released".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_n_i};
    end
  end

  assign s = ~sync_q[1];

  // State, counters and registered event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      db_q    <= '0;
      hold_q  <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      hev_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      db_q    <= db_d;
      hold_q  <= hold_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      hev_q   <= hev_d;
    end
  end

  // Next state and debounce counter; entry cycle counts as one.
  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    unique case (state_q)
      ST_IDLE: begin
        if (s) begin
          state_d = ST_PRESS_WAIT;
          db_d    = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!s) begin
          state_d = ST_IDLE;
          db_d    = '0;
        end else if (db_q == DB_LAST) begin
          state_d = ST_PRESSED;
          db_d    = '0;
        end else begin
          db_d = db_q + DW'(1);
        end
      end
      ST_PRESSED: begin
        if (!s) begin
          state_d = ST_RELEASE_WAIT;
          db_d    = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (s) begin
          state_d = ST_PRESSED;
          db_d    = '0;
        end else if (db_q == DB_LAST) begin
          state_d = ST_IDLE;
          db_d    = '0;
        end else begin
          db_d = db_q + DW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        db_d    = '0;
      end
    endcase
  end

  // Event decode and saturating hold timer.
  always_comb begin
    held    = (state_q == ST_PRESSED) ||
              (state_q == ST_RELEASE_WAIT);
    press_d = (state_q == ST_PRESS_WAIT) &&
              (state_d == ST_PRESSED);
    rel_d   = (state_q == ST_RELEASE_WAIT) &&
              (state_d == ST_IDLE);
    hev_d   = held && (state_d != ST_IDLE) &&
              (hold_q == HOLD_LAST);
    hold_d  = hold_q;
    if (press_d) begin
      hold_d = '0;
    end else if (held && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + HW'(1);
    end
  end

  assign level_o   = held;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign hold_o    = hev_q;

endmodule

// File: rtl/key_debouncer.sv
// Multi-key debouncer for active-low board push-buttons.
// One independent key_channel per key bit.
module key_debouncer
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_hold
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_n_i  (KEY[i]),
      .level_o  (key_level[i]),
      .press_o  (key_press[i]),
      .release_o(key_release[i]),
      .hold_o   (key_hold[i])
    );
  end

endmodule
